// File: rtl/bcd_countdown_timer_if.sv
// rtl/bcd_countdown_timer_if.sv - control and display bundle for the MM:SS countdown timer
interface bcd_countdown_timer_if;
  logic        clear;
  logic        load;
  logic [15:0] preset;
  logic        start_stop;
  logic [15:0] digits;
  logic        running;
  logic        done;
  logic        expired;

  modport master (
    output clear, load, preset, start_stop,
    input  digits, running, done, expired
  );

  modport slave (
    input  clear, load, preset, start_stop,
    output digits, running, done, expired
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - four-digit BCD MM:SS countdown with prescaler and expiry flag
module bcd_countdown_timer #(
  parameter int DIV_COUNT = 100_000_000,
  localparam int PW = $clog2(DIV_COUNT)
) (
  input logic                  clk,
  input logic                  rst_n,
  bcd_countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_COUNT - 1);

  state_t        state, state_n;
  logic [15:0]   digits, digits_n;
  logic [PW-1:0] presc, presc_n;
  logic          expired, expired_n;
  logic [15:0]   digits_dec;
  logic [15:0]   preset_clean;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] max);
    return (v > max) ? max : v;
  endfunction

  // One second off MM:SS; each nibble only moves when everything below it borrowed.
  function automatic logic [15:0] bcd_dec(input logic [15:0] d);
    logic [3:0] su, st, mu, mt;
    logic       b;
    {mt, mu, st, su} = d;
    b = (su == 4'd0);
    su = b ? 4'd9 : su - 4'd1;
    if (b) begin
      b = (st == 4'd0);
      st = b ? 4'd5 : st - 4'd1;
    end
    if (b) begin
      b = (mu == 4'd0);
      mu = b ? 4'd9 : mu - 4'd1;
    end
    if (b) mt = mt - 4'd1;
    return {mt, mu, st, su};
  endfunction

  assign digits_dec   = bcd_dec(digits);
  assign preset_clean = {clamp(bus.preset[15:12], 4'd5), clamp(bus.preset[11:8], 4'd9),
                         clamp(bus.preset[7:4],   4'd5), clamp(bus.preset[3:0],  4'd9)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      digits  <= 16'h0000;
      presc   <= '0;
      expired <= 1'b0;
    end else begin
      state   <= state_n;
      digits  <= digits_n;
      presc   <= presc_n;
      expired <= expired_n;
    end
  end

  always_comb begin
    state_n   = state;
    digits_n  = digits;
    presc_n   = presc;
    expired_n = 1'b0;
    if (bus.clear) begin
      state_n  = IDLE;
      digits_n = 16'h0000;
      presc_n  = '0;
    end else if (bus.load && state != RUN) begin
      state_n  = IDLE;
      digits_n = preset_clean;
      presc_n  = '0;
    end else if (bus.start_stop) begin
      unique case (state)
        IDLE: begin
          if (digits != 16'h0000) begin
            state_n = RUN;
            presc_n = '0;
          end
        end
        RUN:     state_n = PAUSE;
        PAUSE:   state_n = RUN;
        default: state_n = state;
      endcase
    end else if (state == RUN) begin
      if (presc == PRESC_LAST) begin
        presc_n = '0;
        if (digits_dec == 16'h0000) begin
          digits_n  = 16'h0000;
          state_n   = DONE;
          expired_n = 1'b1;
        end else begin
          digits_n = digits_dec;
        end
      end else begin
        presc_n = presc + 1'b1;
      end
    end
  end

  assign bus.digits  = digits;
  assign bus.running = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.expired = expired;

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Sequential MM:SS countdown timer and the down-counting counterpart of the stopwatch's up-counting adder datapath.
- Holds four BCD digits, decrements one second per prescaler period with a BCD borrow chain, and flags expiry.
- Sits between the board button debouncers/one-shots and the 7-segment display mux on the BASYS3 stopwatch design.

Parameters:
- DIV_COUNT, 100_000_000, clk cycles per one-second tick; legal range 2..2^27; benches use 4.
- PW, $clog2(DIV_COUNT), prescaler register width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  one-cycle pulse; zero digits, return to IDLE.
- load  input  1  one-cycle pulse; load preset.
- preset  input  16  BCD preset {min_tens, min_units, sec_tens, sec_units}.
- start_stop  input  1  one-cycle pulse; start, pause or resume.
- digits  output  16  current BCD value, same nibble order as preset; registered.
- running  output  1  high while in RUN.
- done  output  1  high while in DONE.
- expired  output  1  single-cycle pulse on reaching 00:00 from RUN.

Behaviour:
- Reset (rst_n=0, asynchronous): digits=0x0000, state=IDLE, prescaler=0, running=0, done=0, expired=0. Holds until rst_n rises. Takes effect mid-count with no partial update.
- States are IDLE, RUN, PAUSE and DONE. running = (state==RUN). done = (state==DONE). Both are decoded from registered state.
- Input priority, same cycle: clear > load > start_stop.
- clear, any state: digits=0x0000, prescaler=0, state=IDLE.
- load:
  - In IDLE, PAUSE or DONE: digits=sanitized preset, prescaler=0, state=IDLE. A load in DONE clears done.
  - In RUN: ignored.
- Sanitizing, per nibble: sec_units and min_units values >9 become 9. sec_tens and min_tens values >5 become 5.
- start_stop:
  - IDLE with digits≠0 -> RUN, prescaler=0.
  - IDLE with digits==0 -> no change.
  - RUN -> PAUSE; prescaler is held.
  - PAUSE -> RUN; the prescaler resumes from its held value.
  - DONE -> ignored.
- RUN counting:
  - The prescaler counts 0..DIV_COUNT-1.
  - In the cycle when it equals DIV_COUNT-1, it wraps to 0 and the digits decrement by one second.
  - First decrement is registered DIV_COUNT cycles after the start_stop edge.
- BCD borrow chain:
  - sec_units 0->9 with borrow; otherwise -1.
  - sec_tens consumes the borrow: 0->5 with borrow.
  - min_units consumes the borrow: 0->9 with borrow.
  - min_tens consumes the borrow and decrements.
  - digits is never 0x0000 in RUN, so min_tens never underflows.
- Expiry: if the decremented value is 0x0000, on the same edge digits=0x0000, state=DONE and expired=1. expired returns to 0 on the next edge. done stays high until clear, load or reset.
- Outputs change only on clk edges or on rst_n assertion. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset: rst_n low 3 cycles -> digits=0x0000, running=0, done=0, expired=0. Then start_stop with no load -> still IDLE, running=0.
- Borrow chain with DIV_COUNT=4:
  - Load 0x0102, start -> digits 0x0101 after 4 cycles, 0x0100 after 8, 0x0059 after 12.
  - Load 0x1000, run one tick -> 0x0959.
- Pause/resume: start from 0x0010, pause after 2 cycles, hold 10 cycles -> digits unchanged 0x0010, running=0. Resume -> 0x0009 exactly 2 cycles later.
- Expiry:
  - Load 0x0001, start -> on the 4th cycle digits=0x0000, expired high exactly 1 cycle, done=1, running=0.
  - start_stop is then ignored.
  - Load 0x0030 -> done=0, digits=0x0030.
- Sanitize and priority:
  - Preset 0xFA7C loaded -> digits=0x5959.
  - Same-cycle clear+load -> digits=0x0000.
  - Load during RUN -> ignored.
- Asynchronous reset mid-run: assert rst_n between clk edges while running at 0x0123 -> outputs zero immediately. Resume after rst_n rises -> IDLE, no spurious expired.
